// File: rtl/clear_engine_seq_if.sv
// Handshake/data bundle between the board register / piece control and clear_engine_seq.
// The master drives start and the snapshot. The slave (engine) returns the pass results.
interface clear_engine_seq_if #(
    parameter int ROWS    = 8,
    parameter int COLS    = 4,
    parameter int CNT_W   = $clog2(ROWS + 1),
    parameter int SCORE_W = 16
);
    logic                   start;
    logic [ROWS*COLS-1:0]   board_in;
    logic [1:0]             curr_piece;
    logic [ROWS*COLS-1:0]   board_out;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [CNT_W-1:0]       lines_cleared;
    logic [SCORE_W-1:0]     score;

    modport master (
        output start, board_in, curr_piece,
        input  board_out, busy, done, error, lines_cleared, score
    );

    modport slave (
        input  start, board_in, curr_piece,
        output board_out, busy, done, error, lines_cleared, score
    );
endinterface

// File: rtl/clear_engine_seq.sv
// Sequential line-clear and spawn engine: compacts full rows bottom-up, then spawns the next piece.
// Optional macro SCORE_EN builds a saturating cumulative score; otherwise score is tied to 0.
module clear_engine_seq #(
    parameter int ROWS      = 8,
    parameter int COLS      = 4,
    parameter int SPAWN_COL = 1,
    parameter int CNT_W     = $clog2(ROWS + 1),
    parameter int SCORE_W   = 16
) (
    input  logic                 clka,
    input  logic                 reset,
    clear_engine_seq_if.slave    bus
);
    localparam int N     = ROWS * COLS;
    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SPAWN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;

    logic [N-1:0]       r_board;
    logic [1:0]         r_piece;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [N-1:0]       r_board_out;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [CNT_W-1:0]   r_lines;

    logic               w_row_full;
    logic [N-1:0]       w_shifted;
    logic [N-1:0]       w_mask;
    logic               w_collide;

    // ---------------- FSM ----------------
    always_ff @(posedge clka or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SCAN;
            S_SCAN:  if (!w_row_full && r_ptr == '0) w_next = S_SPAWN;
            S_SPAWN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath helpers ----------------
    assign w_row_full = &r_board[r_ptr*COLS +: COLS];

    // Rows above ptr slide down one; row 0 refills with zeros.
    always_comb begin
        w_shifted = r_board;
        for (int r = 0; r < ROWS; r++) begin
            if (r == 0)
                w_shifted[r*COLS +: COLS] = '0;
            else if (PTR_W'(r) <= r_ptr)
                w_shifted[r*COLS +: COLS] = r_board[(r-1)*COLS +: COLS];
        end
    end

    always_comb begin
        w_mask = '0;
        w_mask[SPAWN_COL] = 1'b1;
        case (r_piece)
            2'b01: w_mask[SPAWN_COL+1] = 1'b1;
            2'b10: begin
                w_mask[SPAWN_COL+1]      = 1'b1;
                w_mask[COLS+SPAWN_COL]   = 1'b1;
                w_mask[COLS+SPAWN_COL+1] = 1'b1;
            end
            2'b11: begin
                w_mask[COLS+SPAWN_COL]   = 1'b1;
                w_mask[COLS+SPAWN_COL+1] = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_collide = |(w_mask & r_board);

    // ---------------- working and result registers ----------------
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            r_board     <= '0;
            r_piece     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_board_out <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_lines     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_board <= bus.board_in;
                    r_piece <= bus.curr_piece;
                    r_ptr   <= PTR_W'(ROWS - 1);
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                S_SCAN: begin
                    // A cleared row keeps ptr so the row that fell into it is rechecked.
                    if (w_row_full) begin
                        r_board <= w_shifted;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else if (r_ptr != '0) begin
                        r_ptr   <= r_ptr - PTR_W'(1);
                    end
                end
                S_SPAWN: begin
                    r_err <= w_collide;
                    if (!w_collide) r_board <= r_board | w_mask;
                end
                S_DONE: begin
                    r_board_out <= r_board;
                    r_lines     <= r_cnt;
                    r_error     <= r_err;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_EN
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_inc;
    logic [SCORE_W:0]   w_sum;

    always_comb begin
        w_inc = '0;
        if (r_cnt >= CNT_W'(4)) w_inc = SCORE_W'(8);
        else begin
            case (r_cnt[1:0])
                2'd1:    w_inc = SCORE_W'(1);
                2'd2:    w_inc = SCORE_W'(3);
                2'd3:    w_inc = SCORE_W'(5);
                default: w_inc = '0;
            endcase
        end
    end

    assign w_sum = {1'b0, r_score} + {1'b0, w_inc};

    always_ff @(posedge clka or posedge reset) begin
        if (reset)                  r_score <= '0;
        else if (r_state == S_DONE) r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    end

    assign bus.score = r_score;
`else
    assign bus.score = '0;
`endif

    assign bus.board_out     = r_board_out;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.lines_cleared = r_lines;

endmodule

// File: tb/tb_clear_engine_seq.sv
// Bench for clear_engine_seq: row-compaction model with a per-cycle compare process,
// plus literal expectations for the reference vectors, ignored start and mid-pass reset.
module tb_clear_engine_seq;
    localparam int ROWS = 8, COLS = 4, SPAWN_COL = 1, N = ROWS * COLS;
    localparam int CNT_W = 4, SCORE_W = 16;

    logic clka = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0, bad = 0;

    clear_engine_seq_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .SCORE_W(SCORE_W)) bus ();

    clear_engine_seq #(.ROWS(ROWS), .COLS(COLS), .SPAWN_COL(SPAWN_COL), .CNT_W(CNT_W), .SCORE_W(SCORE_W))
        dut (.clka(clka), .reset(reset), .bus(bus));

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    // expected visible outputs and the pending pass
    logic [N-1:0]       exp_board, nxt_board;
    int                 exp_lines, nxt_lines;
    logic               exp_err, nxt_err;
    int                 exp_score;
    bit                 pend = 0;
    int                 acc_at = 0, done_at = 0, last_done = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int score_tab(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    // Keep every non-full row in bottom-up order, stack them at the bottom, then try the spawn.
    function automatic void model(input logic [N-1:0] b, input logic [1:0] p,
                                  output logic [N-1:0] ob, output int k, output logic e);
        logic [COLS-1:0] kept[$];
        logic [COLS-1:0] row;
        logic [N-1:0]    mask;
        int              cells_r[$], cells_c[$];
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (&row) k++;
            else      kept.push_back(row);
        end
        ob = '0;
        foreach (kept[i]) ob[(ROWS-1-i)*COLS +: COLS] = kept[i];
        case (p)
            2'b00: begin cells_r = '{0};          cells_c = '{0}; end
            2'b01: begin cells_r = '{0, 0};       cells_c = '{0, 1}; end
            2'b10: begin cells_r = '{0, 0, 1, 1}; cells_c = '{0, 1, 0, 1}; end
            default: begin cells_r = '{0, 1, 1};  cells_c = '{0, 0, 1}; end
        endcase
        mask = '0;
        foreach (cells_r[i]) mask[cells_r[i]*COLS + SPAWN_COL + cells_c[i]] = 1'b1;
        e = |(mask & ob);
        if (!e) ob = ob | mask;
    endfunction

    // single per-cycle compare process
    always @(negedge clka) begin
        logic edone, ebusy;
        if (!reset && cyc > 0) begin
            edone = 1'b0;
            if (pend && cyc == done_at) begin
                exp_board = nxt_board;
                exp_lines = nxt_lines;
                exp_err   = nxt_err;
`ifdef SCORE_EN
                exp_score = exp_score + score_tab(nxt_lines);
                if (exp_score > 65535) exp_score = 65535;
`endif
                edone = 1'b1;
                pend  = 0;
            end
            ebusy = pend && (cyc >= acc_at);
            if (bus.done) last_done = cyc;
            chk("done",  bus.done, edone);
            chk("busy",  bus.busy, ebusy);
            chk("board", bus.board_out, exp_board);
            chk("lines", bus.lines_cleared, exp_lines);
            chk("error", bus.error, exp_err);
            chk("score", bus.score, exp_score);
        end
    end

    task automatic launch(input logic [N-1:0] b, input logic [1:0] p);
        int k;
        @(negedge clka);
        bus.start = 1'b1; bus.board_in = b; bus.curr_piece = p;
        model(b, p, nxt_board, k, nxt_err);
        nxt_lines = k;
        acc_at  = cyc + 1;
        done_at = acc_at + ROWS + k + 2;
        pend    = 1;
        @(negedge clka);
        bus.start = 1'b0;
    endtask

    task automatic wait_pass(input string nm);
        int n = 0;
        while (pend && n < 60) begin @(negedge clka); n++; end
        if (pend) begin
            chk({nm, "_timeout"}, 1, 0);
            pend = 0;
        end
        @(negedge clka);
    endtask

    task automatic run(input string nm, input logic [N-1:0] b, input logic [1:0] p,
                       input logic [N-1:0] lb, input int ll, input logic le, input int lat);
        launch(b, p);
        wait_pass(nm);
        chk({nm, "_board"}, bus.board_out, lb);
        chk({nm, "_lines"}, bus.lines_cleared, ll);
        chk({nm, "_err"},   bus.error, le);
        if (lat > 0) chk({nm, "_lat"}, last_done - acc_at, lat);
    endtask

    task automatic model_zero();
        pend = 0; exp_board = '0; exp_lines = 0; exp_err = 1'b0; exp_score = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.board_in = '0; bus.curr_piece = '0;
        model_zero();
        repeat (2) @(posedge clka);
        #1;
        chk("rst_board", bus.board_out, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_err",   bus.error, 0);
        chk("rst_lines", bus.lines_cleared, 0);
        chk("rst_score", bus.score, 0);
        @(posedge clka); #2 reset = 1'b0;

        // all-ones board clears every row
        run("full",  32'hFFFF_FFFF, 2'b00, 32'h0000_0002, 8, 1'b0, 18);
`ifdef SCORE_EN
        chk("score8", bus.score, 8);
`else
        chk("score_tied", bus.score, 0);
`endif
        run("one",   32'hF000_0000, 2'b00, 32'h0000_0002, 1, 1'b0, 11);
`ifdef SCORE_EN
        chk("score9", bus.score, 9);
`endif
        run("two",   32'hFF10_0000, 2'b10, 32'h1000_0066, 2, 1'b0, 12);
        run("gap",   32'hF3F0_0000, 2'b11, 32'h3000_0062, 2, 1'b0, 12);
        run("coll",  32'h0000_0002, 2'b00, 32'h0000_0002, 0, 1'b1, 10);
        run("alt",   32'h0F0F_0F0F, 2'b01, 32'h0000_0006, 4, 1'b0, 14);
        run("c11",   32'h0000_0040, 2'b11, 32'h0000_0040, 0, 1'b1, 10);
        run("ok01",  32'h0000_0040, 2'b01, 32'h0000_0046, 0, 1'b0, 10);
        run("c10",   32'h0000_0040, 2'b10, 32'h0000_0040, 0, 1'b1, 10);

        // start while busy is dropped
        launch(32'hF000_0000, 2'b00);
        repeat (3) @(negedge clka);
        bus.start = 1'b1; bus.board_in = 32'hFFFF_FFFF; bus.curr_piece = 2'b11;
        @(negedge clka);
        bus.start = 1'b0;
        wait_pass("ign");
        chk("ign_board", bus.board_out, 32'h0000_0002);
        chk("ign_lines", bus.lines_cleared, 1);
        repeat (3) @(negedge clka);

        // reset during SCAN aborts the pass
        launch(32'hFF00_0000, 2'b01);
        @(posedge clka); @(posedge clka);
        #2 reset = 1'b1;
        model_zero();
        #1;
        chk("abort_board", bus.board_out, 0);
        chk("abort_busy",  bus.busy, 0);
        chk("abort_done",  bus.done, 0);
        chk("abort_err",   bus.error, 0);
        chk("abort_lines", bus.lines_cleared, 0);
        chk("abort_score", bus.score, 0);
        @(posedge clka); #2 reset = 1'b0;
        repeat (15) @(negedge clka);
        run("after", 32'hF000_0000, 2'b10, 32'h0000_0066, 1, 1'b0, 11);

        repeat (3) @(negedge clka);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
